pkt_assembler: RTL

PKT_ASSEMBLER -- requirements
Module: pkt_assembler

---
 rtl/pkt_assembler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pkt_assembler.sv
// pkt_assembler: builds one packet in byte-addressed memory per start pulse.
//   A 16-bit header (SOP code, ECC-protected type/length) is written at hdr_addr.
//   byte_cnt+1 payload bytes follow from hdr_addr+2, taken from a valid/ready stream.
//   A CRC-8 (poly 0x07, init 0x00) of the payload is written after the payload.
//   done_irq then pulses for one cycle. Address arithmetic wraps modulo 2^14.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   start                begin a packet (ignored unless idle)
//   hdr_addr[13:0]       byte address of the header
//   pkt_type[3:0]        packet type field
//   byte_cnt[3:0]        payload length minus one
//   sop[2:0]             start-of-packet code
//   inj_crc_err          (only with PKT_ASM_CRC_ERR_INJ_EN) corrupt CRC bit 0 of this packet
//   in_data/in_valid/in_ready   payload byte stream
//   mem_addr/mem_we/mem_data_i  memory write port (all zero when no write)
//   busy                 packet in progress
//   done_irq             one-cycle completion pulse
//
// Optional feature macro: PKT_ASM_CRC_ERR_INJ_EN (CRC error injection).

module pkt_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] hdr_addr,
    input  logic [3:0]  pkt_type,
    input  logic [3:0]  byte_cnt,
    input  logic [2:0]  sop,
`ifdef PKT_ASM_CRC_ERR_INJ_EN
    input  logic        inj_crc_err,
`endif
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [13:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_data_i,
    output logic        busy,
    output logic        done_irq
);

    typedef enum logic [2:0] {
        StIdle,
        StHdrWr,
        StData,
        StCrcWr,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [13:0] hdr_addr_q;
    logic [3:0]  pkt_type_q;
    logic [3:0]  byte_cnt_q;
    logic [2:0]  sop_q;
    logic [13:0] addr_q;
    logic [3:0]  remain_q;   // bytes still to accept, minus one
    logic [7:0]  crc_q;
    logic        load;
    logic        accept;
    logic [7:0]  ecc_d;
    logic [3:0]  ecc;
    logic        ecc_msb;
    logic [15:0] hdr_word;
    logic [7:0]  crc_out;

    // One byte of CRC-8, polynomial x^8+x^2+x+1, MSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // Header ECC over {pkt_type, byte_cnt}
    assign ecc_d    = {pkt_type_q, byte_cnt_q};
    assign ecc[0]   = ecc_d[0] ^ ecc_d[1] ^ ecc_d[3] ^ ecc_d[4] ^ ecc_d[6];
    assign ecc[1]   = ecc_d[0] ^ ecc_d[2] ^ ecc_d[3] ^ ecc_d[5] ^ ecc_d[6];
    assign ecc[2]   = ecc_d[1] ^ ecc_d[2] ^ ecc_d[3] ^ ecc_d[7];
    assign ecc[3]   = ecc_d[4] ^ ecc_d[5] ^ ecc_d[6] ^ ecc_d[7];
    assign ecc_msb  = ^ecc_d;
    assign hdr_word = {sop_q, ecc_msb, pkt_type_q, byte_cnt_q, ecc};

`ifdef PKT_ASM_CRC_ERR_INJ_EN
    logic inj_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inj_q <= 1'b0;
        end else if (load) begin
            inj_q <= inj_crc_err;
        end
    end

    assign crc_out = crc_q ^ {7'b0, inj_q};
`else
    assign crc_out = crc_q;
`endif

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        mem_addr   = '0;
        mem_we     = '0;
        mem_data_i = '0;
        done_irq   = 1'b0;
        load       = 1'b0;
        accept     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = StHdrWr;
                end
            end
            StHdrWr: begin
                mem_addr   = hdr_addr_q;
                mem_we     = 4'b0011;
                mem_data_i = {16'h0000, hdr_word};
                state_d    = StData;
            end
            StData: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    mem_addr   = addr_q;
                    mem_we     = 4'b0001;
                    mem_data_i = {24'h000000, in_data};
                    if (remain_q == 4'd0) begin
                        state_d = StCrcWr;
                    end
                end
            end
            StCrcWr: begin
                // addr_q has advanced past the payload: hdr_addr+byte_cnt+3
                mem_addr   = addr_q;
                mem_we     = 4'b0001;
                mem_data_i = {24'h000000, crc_out};
                state_d    = StDone;
            end
            StDone: begin
                done_irq = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_addr_q <= '0;
            pkt_type_q <= '0;
            byte_cnt_q <= '0;
            sop_q      <= '0;
            addr_q     <= '0;
            remain_q   <= '0;
            crc_q      <= '0;
        end else if (load) begin
            hdr_addr_q <= hdr_addr;
            pkt_type_q <= pkt_type;
            byte_cnt_q <= byte_cnt;
            sop_q      <= sop;
            addr_q     <= hdr_addr + 14'd2;
            remain_q   <= byte_cnt;
            crc_q      <= '0;
        end else if (accept) begin
            addr_q   <= addr_q + 14'd1;
            remain_q <= remain_q - 4'd1;
            crc_q    <= crc8_byte(crc_q, in_data);
        end
    end

endmodule
